// File: rtl/accum_irq.sv
// Multi-channel streaming accumulator: per-channel sums emitted on i_last,
// with sticky threshold/overflow interrupt bits cleared by write-one-to-clear.
module accum_irq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  input  logic [CH_W-1:0]   i_ch,
  input  logic              i_last,
  input  logic              i_sat_en,
  input  logic [ACC_W-1:0]  i_thresh,
  input  logic              i_clear,
  input  logic [NUM_CH-1:0] i_intr_ack,
  output logic [ACC_W-1:0]  o_data,
  output logic [CH_W-1:0]   o_ch,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_ovf,
  output logic              o_data_valid,
  output logic [NUM_CH-1:0] o_intr_mask,
  output logic              o_intr
);

  logic [ACC_W-1:0]  acc [NUM_CH];
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] ovf;

  logic [ACC_W:0]    sum;
  logic              smp_ovf;
  logic              burst_ovf;
  logic [ACC_W-1:0]  result;
  logic [CNT_W-1:0]  newcnt;
  logic              accept;
  logic              emit;
  logic [NUM_CH-1:0] set_vec;

  always_comb begin
    sum       = {1'b0, acc[i_ch]} + (ACC_W+1)'(i_data);
    smp_ovf   = sum[ACC_W];
    burst_ovf = ovf[i_ch] | smp_ovf;
    result    = sum[ACC_W-1:0];
    if (smp_ovf && i_sat_en) result = '1;
    newcnt    = (cnt[i_ch] == '1) ? cnt[i_ch] : cnt[i_ch] + 1'b1;
    // i_clear drops any sample in the same cycle
    accept    = i_data_valid && !i_clear;
    emit      = accept && i_last;
    set_vec   = '0;
    if (emit && (burst_ovf || result >= i_thresh)) set_vec[i_ch] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      acc          <= '{default: '0};
      cnt          <= '{default: '0};
      ovf          <= '0;
      o_data       <= '0;
      o_ch         <= '0;
      o_count      <= '0;
      o_ovf        <= '0;
      o_data_valid <= 1'b0;
      o_intr_mask  <= '0;
      o_intr       <= 1'b0;
    end else begin
      if (i_clear) begin
        acc <= '{default: '0};
        cnt <= '{default: '0};
        ovf <= '0;
      end else if (accept) begin
        if (i_last) begin
          acc[i_ch] <= '0;
          cnt[i_ch] <= '0;
          ovf[i_ch] <= 1'b0;
        end else begin
          acc[i_ch] <= result;
          cnt[i_ch] <= newcnt;
          ovf[i_ch] <= burst_ovf;
        end
      end
      o_data_valid <= emit;
      if (emit) begin
        o_data  <= result;
        o_ch    <= i_ch;
        o_count <= newcnt;
        o_ovf   <= burst_ovf;
      end
      // set wins over a simultaneous acknowledge
      o_intr_mask <= (o_intr_mask & ~i_intr_ack) | set_vec;
      o_intr      <= |o_intr_mask;
    end
  end

endmodule

// File: tb/tb_accum_irq.sv
// Directed table-driven bench for accum_irq (32-bit accumulator, 3-bit counter).
module tb_accum_irq;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned CW = 3;
  localparam logic [31:0] TMAX = 32'hFFFF_FFFF;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [DW-1:0] i_data;
  logic          i_data_valid;
  logic [1:0]    i_ch;
  logic          i_last;
  logic          i_sat_en;
  logic [AW-1:0] i_thresh;
  logic          i_clear;
  logic [NC-1:0] i_intr_ack;
  logic [AW-1:0] o_data;
  logic [1:0]    o_ch;
  logic [CW-1:0] o_count;
  logic          o_ovf;
  logic          o_data_valid;
  logic [NC-1:0] o_intr_mask;
  logic          o_intr;

  accum_irq #(.DATA_W(DW), .ACC_W(AW), .NUM_CH(NC), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_data_valid(i_data_valid),
    .i_ch(i_ch), .i_last(i_last), .i_sat_en(i_sat_en), .i_thresh(i_thresh),
    .i_clear(i_clear), .i_intr_ack(i_intr_ack), .o_data(o_data), .o_ch(o_ch),
    .o_count(o_count), .o_ovf(o_ovf), .o_data_valid(o_data_valid),
    .o_intr_mask(o_intr_mask), .o_intr(o_intr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic          rst, clr, v, last, sat;
    logic [1:0]    ch;
    logic [31:0]   data, thr;
    logic [3:0]    ack;
    logic          e_dv;
    logic [31:0]   e_data;
    logic [1:0]    e_ch;
    logic [CW-1:0] e_cnt;
    logic          e_ovf;
    logic [3:0]    e_mask;
    logic          e_intr;
  } vec_t;

  vec_t tv[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(
    input logic rst, clr, v, last, sat, input logic [1:0] ch,
    input logic [31:0] data, thr, input logic [3:0] ack,
    input logic dv, input logic [31:0] ed, input logic [1:0] ech,
    input logic [CW-1:0] ecnt, input logic eovf, input logic [3:0] emask,
    input logic eintr);
    vec_t r;
    r.rst = rst; r.clr = clr; r.v = v; r.last = last; r.sat = sat; r.ch = ch;
    r.data = data; r.thr = thr; r.ack = ack;
    r.e_dv = dv; r.e_data = ed; r.e_ch = ech; r.e_cnt = ecnt; r.e_ovf = eovf;
    r.e_mask = emask; r.e_intr = eintr;
    tv.push_back(r);
  endfunction

  task automatic drive(input logic rst, clr, v, last, sat, input logic [1:0] ch,
                       input logic [31:0] data, thr, input logic [3:0] ack);
    i_rst = rst; i_clear = clr; i_data_valid = v; i_last = last; i_sat_en = sat;
    i_ch = ch; i_data = data; i_thresh = thr; i_intr_ack = ack;
  endtask

  task automatic check(input string name, input logic dv, input logic [31:0] ed,
                       input logic [1:0] ech, input logic [CW-1:0] ecnt,
                       input logic eovf, input logic [3:0] emask, input logic eintr);
    logic [44:0] act, exp;
    act = {o_data_valid, o_data, o_ch, o_count, o_ovf, o_intr_mask, o_intr};
    exp = {dv, ed, ech, ecnt, eovf, emask, eintr};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got dv=%b data=%h ch=%0d cnt=%0d ovf=%b mask=%b intr=%b, want dv=%b data=%h ch=%0d cnt=%0d ovf=%b mask=%b intr=%b",
               name, o_data_valid, o_data, o_ch, o_count, o_ovf, o_intr_mask, o_intr,
               dv, ed, ech, ecnt, eovf, emask, eintr);
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    //  rst clr v last sat ch data thr ack | dv data ch cnt ovf mask intr
    // reset held, then idle
    add(0,0,0,0,0,0,0,0,0,           0,0,0,0,0,4'b0000,0);
    add(0,0,0,0,0,0,0,0,0,           0,0,0,0,0,4'b0000,0);
    add(0,0,0,0,0,0,0,0,0,           0,0,0,0,0,4'b0000,0);
    add(1,0,0,0,0,0,0,0,0,           0,0,0,0,0,4'b0000,0);
    add(1,0,0,0,0,0,0,0,0,           0,0,0,0,0,4'b0000,0);
    // single burst on ch1: 5+7+9
    add(1,0,1,0,0,1,5,1000,0,        0,0,0,0,0,4'b0000,0);
    add(1,0,1,0,0,1,7,1000,0,        0,0,0,0,0,4'b0000,0);
    add(1,0,1,1,0,1,9,1000,0,        1,21,1,3,0,4'b0000,0);
    add(1,0,0,0,0,0,0,1000,0,        0,21,1,3,0,4'b0000,0);
    // interleaved ch0/ch2, thresh 250
    add(1,0,1,0,0,0,10,250,0,        0,21,1,3,0,4'b0000,0);
    add(1,0,1,0,0,2,100,250,0,       0,21,1,3,0,4'b0000,0);
    add(1,0,1,1,0,0,20,250,0,        1,30,0,2,0,4'b0000,0);
    add(1,0,1,1,0,2,200,250,0,       1,300,2,2,0,4'b0100,0);
    add(1,0,0,0,0,0,0,250,0,         0,300,2,2,0,4'b0100,1);
    add(1,0,0,0,0,0,0,250,4'b0100,   0,300,2,2,0,4'b0000,1);
    add(1,0,0,0,0,0,0,250,0,         0,300,2,2,0,4'b0000,0);
    // saturating overflow on ch1
    add(1,0,1,0,1,1,32'hFFFFFFF0,250,0, 0,300,2,2,0,4'b0000,0);
    add(1,0,1,1,1,1,32'h20,250,0,    1,TMAX,1,2,1,4'b0010,0);
    add(1,0,0,0,0,0,0,250,4'b0010,   0,TMAX,1,2,1,4'b0000,1);
    add(1,0,0,0,0,0,0,250,0,         0,TMAX,1,2,1,4'b0000,0);
    // wrapping overflow on ch1; overflow alone raises the bit
    add(1,0,1,0,0,1,32'hFFFFFFF0,TMAX,0, 0,TMAX,1,2,1,4'b0000,0);
    add(1,0,1,1,0,1,32'h20,TMAX,0,   1,32'h10,1,2,1,4'b0010,0);
    add(1,0,0,0,0,0,0,TMAX,4'b0010,  0,32'h10,1,2,1,4'b0000,1);
    add(1,0,0,0,0,0,0,TMAX,0,        0,32'h10,1,2,1,4'b0000,0);
    // overflow mid-burst is remembered through the last sample
    add(1,0,1,0,0,3,TMAX,TMAX,0,     0,32'h10,1,2,1,4'b0000,0);
    add(1,0,1,0,0,3,2,TMAX,0,        0,32'h10,1,2,1,4'b0000,0);
    add(1,0,1,1,0,3,1,TMAX,0,        1,2,3,3,1,4'b1000,0);
    add(1,0,0,0,0,0,0,TMAX,4'b1000,  0,2,3,3,1,4'b0000,1);
    add(1,0,0,0,0,0,0,TMAX,0,        0,2,3,3,1,4'b0000,0);
    // ack races an emit on ch0 that crosses thresh 10
    add(1,0,1,0,0,0,5,10,0,          0,2,3,3,1,4'b0000,0);
    add(1,0,1,1,0,0,6,10,4'b0001,    1,11,0,2,0,4'b0001,0);
    add(1,0,0,0,0,0,0,10,0,          0,11,0,2,0,4'b0001,1);
    add(1,0,0,0,0,0,0,10,4'b0001,    0,11,0,2,0,4'b0000,1);
    add(1,0,0,0,0,0,0,10,0,          0,11,0,2,0,4'b0000,0);
    // result equal to thresh, then back-to-back strobe below it
    add(1,0,1,1,0,2,7,7,0,           1,7,2,1,0,4'b0100,0);
    add(1,0,1,1,0,1,3,7,0,           1,3,1,1,0,4'b0100,1);
    add(1,0,0,0,0,0,0,7,4'b0100,     0,3,1,1,0,4'b0000,1);
    add(1,0,0,0,0,0,0,7,0,           0,3,1,1,0,4'b0000,0);
    // clear mid-burst on ch3 drops the concurrent sample
    add(1,0,1,0,0,3,50,TMAX,0,       0,3,1,1,0,4'b0000,0);
    add(1,1,1,0,0,3,60,TMAX,0,       0,3,1,1,0,4'b0000,0);
    add(1,0,1,1,0,3,70,TMAX,0,       1,70,3,1,0,4'b0000,0);
    // raise a mask bit, then reset mid-burst on ch3
    add(1,0,1,1,0,0,1,0,0,           1,1,0,1,0,4'b0001,0);
    add(1,0,1,0,0,3,50,TMAX,0,       0,1,0,1,0,4'b0001,1);
    add(0,0,1,0,0,3,60,TMAX,0,       0,0,0,0,0,4'b0000,0);
    add(1,0,1,1,0,3,70,TMAX,0,       1,70,3,1,0,4'b0000,0);
    add(1,0,0,0,0,0,0,TMAX,0,        0,70,3,1,0,4'b0000,0);
    // clear leaves interrupts alone
    add(1,0,1,1,0,1,4,0,0,           1,4,1,1,0,4'b0010,0);
    add(1,1,0,0,0,0,0,0,0,           0,4,1,1,0,4'b0010,1);
    add(1,0,0,0,0,0,0,0,4'b0010,     0,4,1,1,0,4'b0000,1);
    add(1,0,0,0,0,0,0,0,0,           0,4,1,1,0,4'b0000,0);
    // i_last without i_data_valid is ignored
    add(1,0,0,1,0,2,9,0,0,           0,4,1,1,0,4'b0000,0);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].clr, tv[i].v, tv[i].last, tv[i].sat, tv[i].ch,
            tv[i].data, tv[i].thr, tv[i].ack);
      @(posedge i_clk); #1;
      check($sformatf("row%0d", i), tv[i].e_dv, tv[i].e_data, tv[i].e_ch, tv[i].e_cnt,
            tv[i].e_ovf, tv[i].e_mask, tv[i].e_intr);
    end

    // sample counter saturates at all-ones (7 for a 3-bit counter)
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 1, 0, 0, 0, 1, TMAX, 0);
      @(posedge i_clk); #1;
      check($sformatf("cntsat_acc%0d", k), 0, 4, 1, 1, 0, 4'b0000, 0);
    end
    drive(1, 0, 1, 1, 0, 0, 1, TMAX, 0);
    @(posedge i_clk); #1;
    check("cntsat_emit", 1, 9, 0, 7, 0, 4'b0000, 0);
    drive(1, 0, 0, 0, 0, 0, 0, TMAX, 0);
    @(posedge i_clk); #1;
    check("cntsat_hold", 0, 9, 0, 7, 0, 4'b0000, 0);

    // channel state was zeroed by the emit: a fresh single-sample burst
    drive(1, 0, 1, 1, 0, 0, 3, TMAX, 0);
    @(posedge i_clk); #1;
    check("post_emit_fresh", 1, 3, 0, 1, 0, 4'b0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
